// File: rtl/settings_menu_ctrl.sv
// Settings menu sequencer: open/close, row navigation with hold-to-repeat,
// one-cycle apply/cancel strobes and inactivity auto-close.
module settings_menu_ctrl #(
  parameter int NUM_OPTIONS    = 4,
  parameter int HOLD_CYCLES    = 25000000,
  parameter int REPEAT_CYCLES  = 6250000,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       menu_open_req,
  input  logic [9:0] key_is_pressed,
  output logic       menu_active,
  output logic [2:0] hovered_idx,
  output logic       apply_pulse,
  output logic       cancel_pulse,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {CLOSED, NAV, APPLY} state_t;

  localparam logic [2:0]  IDX_MAX     = 3'(NUM_OPTIONS - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] HOLD_RELOAD = 32'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [31:0] IDLE_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [9:0]  key_d;
  logic        open_d;
  logic [31:0] hold_cnt, hold_nxt;
  logic [31:0] idle_cnt, idle_nxt;
  logic [2:0]  idx_nxt;
  logic        act_nxt, apply_nxt, cancel_nxt, tout_nxt;

  logic [9:0] press;
  logic       open_rise, up_p, dn_p, up_h, dn_h, one_held;
  logic       rep_step, activity, mv_up, mv_dn;

  assign press     = key_is_pressed & ~key_d;
  assign open_rise = menu_open_req & ~open_d;
  assign up_p      = press[8];
  assign dn_p      = press[2];
  assign up_h      = key_is_pressed[8];
  assign dn_h      = key_is_pressed[2];
  assign one_held  = up_h ^ dn_h;

  // A repeat step needs a steady single-key hold; any fresh up/down edge restarts the hold.
  assign rep_step = (state == NAV) && one_held && !up_p && !dn_p && (hold_cnt == HOLD_LAST);
  assign activity = (|press) || rep_step;
  assign mv_up    = (up_p && !dn_p) || (rep_step && up_h);
  assign mv_dn    = (dn_p && !up_p) || (rep_step && dn_h);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLOSED;
      key_d        <= '0;
      open_d       <= 1'b0;
      hold_cnt     <= '0;
      idle_cnt     <= '0;
      menu_active  <= 1'b0;
      hovered_idx  <= '0;
      apply_pulse  <= 1'b0;
      cancel_pulse <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nxt;
      key_d        <= key_is_pressed;
      open_d       <= menu_open_req;
      hold_cnt     <= hold_nxt;
      idle_cnt     <= idle_nxt;
      menu_active  <= act_nxt;
      hovered_idx  <= idx_nxt;
      apply_pulse  <= apply_nxt;
      cancel_pulse <= cancel_nxt;
      timeout_flag <= tout_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = hovered_idx;
    act_nxt    = 1'b0;
    apply_nxt  = 1'b0;
    cancel_nxt = 1'b0;
    tout_nxt   = 1'b0;
    hold_nxt   = '0;
    idle_nxt   = '0;
    case (state)
      CLOSED: begin
        if (open_rise) begin
          state_nxt = NAV;
          act_nxt   = 1'b1;
          idx_nxt   = '0;
        end
      end
      NAV: begin
        act_nxt = 1'b1;
        if (up_p || dn_p || !one_held) hold_nxt = '0;
        else if (rep_step)              hold_nxt = HOLD_RELOAD;
        else                            hold_nxt = hold_cnt + 32'd1;
        idle_nxt = activity ? '0 : idle_cnt + 32'd1;
        if (press[0]) begin
          state_nxt  = CLOSED;
          act_nxt    = 1'b0;
          cancel_nxt = 1'b1;
        end else if (press[5]) begin
          state_nxt = APPLY;
          act_nxt   = 1'b0;
          apply_nxt = 1'b1;
        end else if ((idle_cnt == IDLE_LAST) && !activity) begin
          state_nxt  = CLOSED;
          act_nxt    = 1'b0;
          cancel_nxt = 1'b1;
          tout_nxt   = 1'b1;
        end else if (mv_up) begin
          idx_nxt = (hovered_idx == 3'd0) ? IDX_MAX : hovered_idx - 3'd1;
        end else if (mv_dn) begin
          idx_nxt = (hovered_idx == IDX_MAX) ? 3'd0 : hovered_idx + 3'd1;
        end
      end
      APPLY: state_nxt = CLOSED;
      default: state_nxt = CLOSED;
    endcase
  end

endmodule
